// File: rtl/seq_pkg.sv
// Shared types and limits for the serial pattern detector.
// PAT_W legality is evaluated here so every user applies the same rule.
package seq_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } det_state_t;

    localparam int PAT_W_MIN = 2;
    localparam int PAT_W_MAX = 32;

    function automatic bit pat_w_legal(input int w);
        return (w >= PAT_W_MIN) && (w <= PAT_W_MAX);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear that sticks at all-ones.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/serial_pattern_detector.sv
// Runtime-loadable serial sequence detector with overlap select,
// valid-qualified input and a saturating match counter.
module serial_pattern_detector
    import seq_pkg::*;
#(
    parameter int PAT_W = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in,
    input  logic             in_valid,
    input  logic [PAT_W-1:0] pattern,
    input  logic             pattern_load,
    input  logic             overlap,
    output logic             out,
    output logic [CNT_W-1:0] match_count,
    output logic             armed
);

    localparam int FILL_W = $clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0] FULL = FILL_W'(PAT_W);

    generate
        if (!pat_w_legal(PAT_W)) begin : g_bad_pat_w
            $error("serial_pattern_detector: PAT_W must be within 2..32");
        end
    endgenerate

    det_state_t        state, state_n;
    logic [PAT_W-1:0]  pat_reg, pat_n;
    logic [PAT_W-1:0]  hist, hist_n, shifted;
    logic [FILL_W-1:0] fill, fill_n, fill_inc;
    logic              hit;

    assign shifted  = {hist[PAT_W-2:0], in};
    assign fill_inc = (fill == FULL) ? FULL : fill + 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            pat_reg <= '0;
            hist    <= '0;
            fill    <= '0;
            out     <= 1'b0;
            armed   <= 1'b0;
        end else begin
            state   <= state_n;
            pat_reg <= pat_n;
            hist    <= hist_n;
            fill    <= fill_n;
            out     <= hit;
            if (pattern_load) armed <= 1'b1;
        end
    end

    // Load wins over a bit presented in the same cycle; that bit is dropped.
    always_comb begin
        state_n = state;
        pat_n   = pat_reg;
        hist_n  = hist;
        fill_n  = fill;
        hit     = 1'b0;
        if (pattern_load) begin
            state_n = RUN;
            pat_n   = pattern;
            hist_n  = '0;
            fill_n  = '0;
        end else if (state == RUN && in_valid) begin
            hist_n = shifted;
            hit    = (fill_inc == FULL) && (shifted == pat_reg);
            // Non-overlap consumes the matched bits; overlap keeps the window full.
            fill_n = (hit && !overlap) ? '0 : fill_inc;
        end
    end

    sat_counter #(.W(CNT_W)) u_match_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (pattern_load),
        .inc   (hit),
        .count (match_count)
    );

endmodule

// File: tb/tb_serial_pattern_detector.sv
// Two detectors (PAT_W=4/CNT_W=8 and PAT_W=2/CNT_W=2) share one stream and are
// compared each cycle against a bit-list model of the matching rules.
module tb_serial_pattern_detector;

    logic       clk = 1'b0;
    logic       reset, din, in_valid, pattern_load, overlap;
    logic [3:0] pat4;
    logic [1:0] pat2;
    logic       out4, out2, armed4, armed2;
    logic [7:0] cnt4;
    logic [1:0] cnt2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    serial_pattern_detector #(.PAT_W(4), .CNT_W(8)) dut4 (
        .clk(clk), .reset(reset), .in(din), .in_valid(in_valid),
        .pattern(pat4), .pattern_load(pattern_load), .overlap(overlap),
        .out(out4), .match_count(cnt4), .armed(armed4)
    );

    serial_pattern_detector #(.PAT_W(2), .CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .in(din), .in_valid(in_valid),
        .pattern(pat2), .pattern_load(pattern_load), .overlap(overlap),
        .out(out2), .match_count(cnt2), .armed(armed2)
    );

    // Model: list of valid bits received since the last clear, per lane.
    int W   [2] = '{4, 2};
    int MAX [2] = '{255, 3};
    int mpat[2];
    bit seq [2][64];
    int len [2];
    int mcnt[2];
    bit marm[2];
    bit mout[2];

    task automatic model_step(input bit r, input bit ld, input bit v,
                              input bit b, input bit ov);
        for (int l = 0; l < 2; l++) begin
            mout[l] = 1'b0;
            if (r) begin
                len[l] = 0; mcnt[l] = 0; marm[l] = 1'b0; mpat[l] = 0;
            end else if (ld) begin
                mpat[l] = (l == 0) ? int'(pat4) : int'(pat2);
                len[l] = 0; mcnt[l] = 0; marm[l] = 1'b1;
            end else if (marm[l] && v) begin
                bit m;
                seq[l][len[l]] = b;
                len[l]++;
                m = (len[l] >= W[l]);
                for (int i = 0; i < W[l] && m; i++)
                    if (seq[l][len[l]-W[l]+i] != mpat[l][W[l]-1-i]) m = 1'b0;
                if (m) begin
                    mout[l] = 1'b1;
                    if (mcnt[l] < MAX[l]) mcnt[l]++;
                    if (!ov) len[l] = 0;
                end
                if (len[l] >= 63) begin
                    for (int i = 0; i < 32; i++) seq[l][i] = seq[l][i + len[l] - 32];
                    len[l] = 32;
                end
            end
        end
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic compare_all();
        chk("out4",   int'(out4),   int'(mout[0]));
        chk("cnt4",   int'(cnt4),   mcnt[0]);
        chk("armed4", int'(armed4), int'(marm[0]));
        chk("out2",   int'(out2),   int'(mout[1]));
        chk("cnt2",   int'(cnt2),   mcnt[1]);
        chk("armed2", int'(armed2), int'(marm[1]));
    endtask

    // Drive one cycle away from the edge, update the model at the edge, check #1 later.
    task automatic cyc(input bit r, input bit ld, input bit v, input bit b, input bit ov);
        @(negedge clk);
        reset = r; pattern_load = ld; in_valid = v; din = b; overlap = ov;
        @(posedge clk);
        model_step(r, ld, v, b, ov);
        #1;
        compare_all();
    endtask

    task automatic load(input logic [3:0] p4, input logic [1:0] p2, input bit ov);
        pat4 = p4; pat2 = p2;
        cyc(0, 1, 0, 0, ov);
    endtask

    task automatic stream(input logic [15:0] bits, input int n, input bit ov, input int gap);
        for (int i = n - 1; i >= 0; i--) begin
            cyc(0, 0, 1, bits[i], ov);
            for (int g = 0; g < gap; g++) cyc(0, 0, 0, 1'b1, ov);
        end
    endtask

    int pulses;

    initial begin
        reset = 1; din = 0; in_valid = 0; pattern_load = 0; overlap = 0;
        pat4 = '0; pat2 = '0;
        for (int l = 0; l < 2; l++) begin
            len[l] = 0; mcnt[l] = 0; marm[l] = 0; mout[l] = 0; mpat[l] = 0;
        end
        cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        chk("reset_cnt4", int'(cnt4), 0);

        // Unloaded detector ignores a stream equal to its zero pattern.
        stream(16'b0000, 4, 1, 0);
        chk("idle_armed4", int'(armed4), 0);
        chk("idle_out4", int'(out4), 0);

        load(4'b1011, 2'b11, 1);
        stream(16'b1011011, 7, 1, 0);
        chk("ovl_1011_cnt", int'(cnt4), 2);

        load(4'b1011, 2'b11, 0);
        stream(16'b1011011, 7, 0, 0);
        chk("novl_1011_cnt", int'(cnt4), 1);

        // 1111 overlapped: pulses on three consecutive cycles; lane 2 saturates.
        load(4'b1111, 2'b11, 1);
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            cyc(0, 0, 1, 1, 1);
            if (i >= 3) begin
                chk("ovl_1111_pulse", int'(out4), 1);
                pulses++;
            end
        end
        chk("ovl_1111_cnt", int'(cnt4), 3);
        cyc(0, 0, 1, 1, 1);
        chk("sat_cnt2", int'(cnt2), 3);

        // Load together with a valid bit: the bit is dropped, counts clear.
        pat4 = 4'b1111; pat2 = 2'b11;
        cyc(0, 1, 1, 1, 1);
        chk("load_clr_cnt2", int'(cnt2), 0);

        load(4'b1111, 2'b11, 0);
        stream(16'b111111, 6, 0, 0);
        chk("novl_1111_cnt", int'(cnt4), 1);

        load(4'b1011, 2'b10, 1);
        stream(16'b1011, 4, 1, 3);
        chk("gap_cnt4", int'(cnt4), 1);

        // Reset mid-match leaves the detector unarmed until reloaded.
        load(4'b1011, 2'b01, 1);
        stream(16'b101, 3, 1, 0);
        cyc(1, 0, 0, 0, 1);
        stream(16'b1011, 4, 1, 0);
        chk("rst_no_match", int'(cnt4), 0);
        load(4'b1011, 2'b01, 1);
        stream(16'b1011, 4, 1, 0);
        chk("reload_cnt4", int'(cnt4), 1);

        // Randomized phase: loads, resets, gaps and overlap flips mixed.
        for (int i = 0; i < 600; i++) begin
            bit r, ld;
            r  = ($urandom_range(0, 99) == 0);
            ld = ($urandom_range(0, 39) == 0);
            if (ld) begin
                pat4 = 4'($urandom_range(0, 15));
                pat2 = 2'($urandom_range(0, 3));
            end
            cyc(r, ld, ($urandom_range(0, 9) < 7), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
